// File: rtl/float_divider_if.sv
// Start/done handshake bundle shared by the float arithmetic blocks.
//   start  : request, sampled by the divider only while idle
//   a, b   : dividend / divisor, IEEE 754 single
//   result : quotient, held until the next completion
//   done   : one-cycle completion pulse, result valid alongside it
//   busy   : high from the accept edge until done
interface float_divider_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        done;
  logic        busy;

  modport master (output start, a, b, input result, done, busy);
  modport slave  (input start, a, b, output result, done, busy);
endinterface

// File: rtl/float_divider.sv
// Iterative IEEE 754 single-precision divider, result = a / b.
// Restoring division, one quotient bit per cycle, round-to-nearest-even,
// subnormals flushed to zero. Fixed 27-cycle latency for every operand
// class so it can be scheduled like the other float blocks.
//   clk   : system clock
//   rst_n : asynchronous active-low reset, aborts any operation in flight
//   bus   : slave side of float_divider_if (start/a/b in, result/done/busy out)
//
// state | meaning
// IDLE  | waiting for start, operands are captured on the accept edge
// DIV   | ITER restoring-division steps, one quotient bit per edge
// NORM  | normalise, round, pack; pulse done and drop busy
module float_divider #(
  parameter logic [31:0] QNAN = 32'h7FC0_0000,
  parameter int          ITER = 26
) (
  input logic             clk,
  input logic             rst_n,
  float_divider_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;
  typedef enum logic [1:0] {CLS_NORMAL, CLS_NAN, CLS_INF, CLS_ZERO} cls_t;

  state_t            state;
  cls_t              cls;
  cls_t              cls_in;
  logic              sign;
  logic signed [9:0] exp_diff;
  logic [23:0]       mb;
  logic [25:0]       rem;
  logic [25:0]       q;
  logic [4:0]        cnt;

  // Operand classification; an exponent of zero means zero (FTZ on input).
  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

  always_comb begin
    a_zero = (bus.a[30:23] == 8'h00);
    b_zero = (bus.b[30:23] == 8'h00);
    a_inf  = (bus.a[30:23] == 8'hFF) && (bus.a[22:0] == 23'd0);
    b_inf  = (bus.b[30:23] == 8'hFF) && (bus.b[22:0] == 23'd0);
    a_nan  = (bus.a[30:23] == 8'hFF) && (bus.a[22:0] != 23'd0);
    b_nan  = (bus.b[30:23] == 8'hFF) && (bus.b[22:0] != 23'd0);
    cls_in = CLS_NORMAL;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      cls_in = CLS_NAN;
    else if (a_inf || b_zero)
      cls_in = CLS_INF;
    else if (a_zero || b_inf)
      cls_in = CLS_ZERO;
  end

  // One restoring step: subtract when the remainder covers the divisor.
  logic        q_bit;
  logic [25:0] rem_sub;

  always_comb begin
    q_bit   = (rem >= {2'b00, mb});
    rem_sub = q_bit ? (rem - {2'b00, mb}) : rem;
  end

  // Normalise and round. The rounding increment is added to the packed
  // {exponent, fraction} so a mantissa carry-out lands in the exponent,
  // leaving a zero fraction (mantissa 1.0) as required.
  logic [22:0]       frac;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic signed [9:0] exp_n;
  logic [32:0]       sum;
  logic signed [9:0] exp_r;
  logic [31:0]       packed_res;

  always_comb begin
    if (q[25]) begin
      frac   = q[24:2];
      guard  = q[1];
      sticky = q[0] | (|rem);
      exp_n  = exp_diff + 10'sd127;
    end else begin
      frac   = q[23:1];
      guard  = q[0];
      sticky = |rem;
      exp_n  = exp_diff + 10'sd126;
    end
    round_up = guard & (sticky | frac[0]);
    sum      = {exp_n, frac} + {32'd0, round_up};
    exp_r    = sum[32:23];
    case (cls)
      CLS_NAN:  packed_res = QNAN;
      CLS_INF:  packed_res = {sign, 8'hFF, 23'd0};
      CLS_ZERO: packed_res = {sign, 31'd0};
      default: begin
        if (exp_r >= 10'sd255)
          packed_res = {sign, 8'hFF, 23'd0};
        else if (exp_r <= 10'sd0)
          packed_res = {sign, 31'd0};
        else
          packed_res = {sign, exp_r[7:0], sum[22:0]};
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cls        <= CLS_NORMAL;
      sign       <= 1'b0;
      exp_diff   <= '0;
      mb         <= '0;
      rem        <= '0;
      q          <= '0;
      cnt        <= '0;
      bus.result <= '0;
      bus.done   <= 1'b0;
      bus.busy   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sign     <= bus.a[31] ^ bus.b[31];
            exp_diff <= $signed({2'b00, bus.a[30:23]}) - $signed({2'b00, bus.b[30:23]});
            rem      <= {3'b001, bus.a[22:0]};
            mb       <= {1'b1, bus.b[22:0]};
            q        <= '0;
            cls      <= cls_in;
            cnt      <= 5'(ITER - 1);
            bus.busy <= 1'b1;
            state    <= DIV;
          end
        end
        DIV: begin
          q   <= {q[24:0], q_bit};
          rem <= rem_sub << 1;
          if (cnt == 5'd0)
            state <= NORM;
          else
            cnt <= cnt - 5'd1;
        end
        NORM: begin
          bus.result <= packed_res;
          bus.done   <= 1'b1;
          bus.busy   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_divider.sv
// Self-checking bench for float_divider: directed vectors with known
// quotients, handshake timing, ignored starts, mid-operation reset, and
// random operands compared against an integer-arithmetic reference.
module tb_float_divider;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  float_divider_if bus ();

  float_divider dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: exact quotient from a wide integer divide, rounded to
  // nearest-even by comparing the discarded bits against one half ulp.
  function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    logic s;
    int ex, ey, e, sh;
    bit xz, xi, xn, yz, yi, yn, up;
    longint unsigned num, den, qq, rr, low, half, mant;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xz = (ex == 0);
    yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 0);
    yi = (ey == 255) && (y[22:0] == 0);
    xn = (ex == 255) && (x[22:0] != 0);
    yn = (ey == 255) && (y[22:0] != 0);
    if (xn || yn || (xz && yz) || (xi && yi)) return 32'h7FC0_0000;
    if (xi || yz) return {s, 8'hFF, 23'd0};
    if (xz || yi) return {s, 31'd0};
    num = 64'({1'b1, x[22:0]}) << 40;
    den = 64'({1'b1, y[22:0]});
    qq  = num / den;
    rr  = num % den;
    e   = ex - ey + 126;
    sh  = 16;
    if (qq >= (64'd1 << 40)) begin
      e++;
      sh = 17;
    end
    mant = qq >> sh;
    low  = qq & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    up   = (low > half) || ((low == half) && ((rr != 0) || mant[0]));
    if (up) mant++;
    if (mant == (64'd1 << 24)) begin
      mant = 64'd1 << 23;
      e++;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, 8'(e), 23'(mant)};
  endfunction

  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) break;
    end
  endtask

  task automatic do_op(input logic [31:0] xa, input logic [31:0] xb,
                       input logic [31:0] exp, input string tag);
    int lat;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = xa;
    bus.b     = xb;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    check({tag, "_busy_acc"}, 32'(bus.busy), 32'd1);
    wait_done(lat);
    check({tag, "_latency"}, 32'(lat), 32'd27);
    check({tag, "_result"}, bus.result, exp);
    check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] specials [7];
    int sel;
    specials = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                 32'h7FC0_0000, 32'h0040_0000, 32'h7F81_2345};
    sel = $urandom_range(0, 9);
    if (sel == 0) return $urandom;
    if (sel == 1) return specials[$urandom_range(0, 6)];
    if (sel <= 3) return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
    return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  initial begin
    int lat, ndone, done_k;
    logic [31:0] ra, rb;
    n_checks  = 0;
    n_errors  = 0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst_n     = 1'b1;
    #2 rst_n  = 1'b0;
    #1;
    check("rst_result", bus.result, 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, "six_by_two");
    do_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, "one_third");
    do_op(32'hC100_0000, 32'h3F00_0000, 32'hC180_0000, "neg8_by_half");
    do_op(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, "x_by_zero");
    do_op(32'h8000_0000, 32'h0000_0000, 32'h7FC0_0000, "zero_by_zero");
    do_op(32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, "inf_by_inf");
    do_op(32'h0000_0000, 32'hC000_0000, 32'h8000_0000, "zero_by_x");
    do_op(32'h4000_0000, 32'hFF80_0000, 32'h8000_0000, "x_by_ninf");
    do_op(32'h7FC1_0000, 32'h3F80_0000, 32'h7FC0_0000, "nan_in");
    do_op(32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, "overflow");
    do_op(32'h0080_0000, 32'h4000_0000, 32'h0000_0000, "underflow");
    do_op(32'h0040_0000, 32'h4000_0000, 32'h0000_0000, "subnorm_a");
    do_op(32'h4000_0000, 32'h0040_0000, 32'h7F80_0000, "subnorm_b");

    // starts at T+5 and T+27 must be ignored; T+28 is accepted
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'h40C0_0000;
    bus.b     = 32'h4000_0000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    ndone  = 0;
    done_k = 0;
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk);
      bus.start = (k == 5) || (k == 27);
      bus.a     = $urandom;
      bus.b     = $urandom;
      @(posedge clk);
      #1;
      if (bus.done) begin
        ndone++;
        done_k = k;
      end
    end
    check("ign_done_count", 32'(ndone), 32'd1);
    check("ign_done_cycle", 32'(done_k), 32'd27);
    check("ign_result", bus.result, 32'h4040_0000);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'h3F80_0000;
    bus.b     = 32'h4040_0000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("t28_busy", 32'(bus.busy), 32'd1);
    wait_done(lat);
    check("t28_latency", 32'(lat), 32'd27);
    check("t28_result", bus.result, 32'h3EAA_AAAB);

    // reset mid-operation
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'h40C0_0000;
    bus.b     = 32'h4000_0000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_result", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (35) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    do_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, "after_reset");

    for (int i = 0; i < 150; i++) begin
      ra = rand_operand();
      rb = rand_operand();
      do_op(ra, rb, ref_div(ra, rb), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
